// File: rtl/ysyx_23060201_lsu_wb_if.sv
// ysyx_23060201_lsu_wb_if: EXU hand-off, data-memory bus
// and GPR write port of the load/store + write-back stage.
interface ysyx_23060201_lsu_wb_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_is_load;
   logic                  in_is_store;
   logic [2:0]            in_funct3;
   logic [DATA_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_sdata;
   logic [DATA_WIDTH-1:0] in_alu_res;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_rd_wen;
   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [3:0]            mem_wmask;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  gpr_wen;
   logic [ADDR_WIDTH-1:0] gpr_waddr;
   logic [DATA_WIDTH-1:0] gpr_wdata;
   logic                  done;
   logic                  err;

   modport master (
      output in_valid, in_is_load, in_is_store, in_funct3,
      output in_addr, in_sdata, in_alu_res, in_rd, in_rd_wen,
      output mem_ack, mem_rdata,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_wmask, gpr_wen, gpr_waddr, gpr_wdata, done, err
   );

   modport slave (
      input  in_valid, in_is_load, in_is_store, in_funct3,
      input  in_addr, in_sdata, in_alu_res, in_rd, in_rd_wen,
      input  mem_ack, mem_rdata,
      output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
      output mem_wmask, gpr_wen, gpr_waddr, gpr_wdata, done, err
   );
endinterface

// File: rtl/ysyx_23060201_lsu_wb.sv
// ysyx_23060201_lsu_wb: load/store + write-back stage.
// One instruction in flight; all outputs except in_ready registered.
module ysyx_23060201_lsu_wb #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input logic                   clk,
   input logic                   rst,
   ysyx_23060201_lsu_wb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MEM, WB, ERR} state_t;

   state_t                state, state_n;
   logic                  is_load_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic                  rd_wen_q;

   logic                  req_q, req_n;
   logic                  we_q, we_n;
   logic [DATA_WIDTH-1:0] maddr_q, maddr_n;
   logic [DATA_WIDTH-1:0] mwdata_q, mwdata_n;
   logic [3:0]            wmask_q, wmask_n;
   logic                  wen_q, wen_n;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_n;
   logic [DATA_WIDTH-1:0] gdata_q, gdata_n;
   logic                  done_q, done_n;
   logic                  err_q, err_n;

   logic                  is_mem, f3_bad, sz_bad, bad;
   logic [3:0]            st_mask;
   logic [DATA_WIDTH-1:0] shifted, ld_data;

   assign is_mem = bus.in_is_load || bus.in_is_store;

   // reject illegal size/sign encodings and misaligned addresses
   always_comb begin
      f3_bad = 1'b0;
      sz_bad = 1'b0;
      if (bus.in_is_load)
         f3_bad = (bus.in_funct3 == 3'd3) || (bus.in_funct3 == 3'd6) ||
                  (bus.in_funct3 == 3'd7);
      else
         f3_bad = bus.in_funct3[2] || (bus.in_funct3[1:0] == 2'd3);
      unique case (bus.in_funct3[1:0])
         2'd1:    sz_bad = bus.in_addr[0];
         2'd2:    sz_bad = |bus.in_addr[1:0];
         default: sz_bad = 1'b0;
      endcase
      bad = (bus.in_is_load && bus.in_is_store) || f3_bad || sz_bad;
   end

   // byte enables for the store lane
   always_comb begin
      st_mask = 4'b1111;
      unique case (bus.in_funct3[1:0])
         2'd0:    st_mask = 4'b0001 << bus.in_addr[1:0];
         2'd1:    st_mask = 4'b0011 << bus.in_addr[1:0];
         default: st_mask = 4'b1111;
      endcase
   end

   assign shifted = bus.mem_rdata >> {off_q, 3'b000};

   // align and extend returning load data
   always_comb begin
      ld_data = shifted;
      unique case (f3_q)
         3'd0:    ld_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'd1:    ld_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'd4:    ld_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         3'd5:    ld_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

   // next state and next registered outputs
   always_comb begin
      state_n  = state;
      req_n    = 1'b0;
      we_n     = we_q;
      maddr_n  = maddr_q;
      mwdata_n = mwdata_q;
      wmask_n  = wmask_q;
      wen_n    = 1'b0;
      waddr_n  = waddr_q;
      gdata_n  = gdata_q;
      done_n   = 1'b0;
      err_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               if (is_mem && bad) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else if (is_mem) begin
                  state_n  = MEM;
                  req_n    = 1'b1;
                  we_n     = bus.in_is_store;
                  maddr_n  = {bus.in_addr[DATA_WIDTH-1:2], 2'b00};
                  mwdata_n = bus.in_sdata << {bus.in_addr[1:0], 3'b000};
                  wmask_n  = st_mask;
               end else begin
                  state_n = WB;
                  wen_n   = bus.in_rd_wen && (|bus.in_rd);
                  waddr_n = bus.in_rd;
                  gdata_n = bus.in_alu_res;
                  done_n  = 1'b1;
               end
            end
         end
         MEM: begin
            if (bus.mem_ack) begin
               done_n = 1'b1;
               if (is_load_q) begin
                  state_n = WB;
                  wen_n   = rd_wen_q && (|rd_q);
                  waddr_n = rd_q;
                  gdata_n = ld_data;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               req_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state, captured instruction fields and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         is_load_q <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
         rd_q      <= '0;
         rd_wen_q  <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         maddr_q   <= '0;
         mwdata_q  <= '0;
         wmask_q   <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         gdata_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state    <= state_n;
         req_q    <= req_n;
         we_q     <= we_n;
         maddr_q  <= maddr_n;
         mwdata_q <= mwdata_n;
         wmask_q  <= wmask_n;
         wen_q    <= wen_n;
         waddr_q  <= waddr_n;
         gdata_q  <= gdata_n;
         done_q   <= done_n;
         err_q    <= err_n;
         if (state == IDLE && bus.in_valid) begin
            is_load_q <= bus.in_is_load;
            f3_q      <= bus.in_funct3;
            off_q     <= bus.in_addr[1:0];
            rd_q      <= bus.in_rd;
            rd_wen_q  <= bus.in_rd_wen;
         end
      end
   end

   assign bus.in_ready  = !rst && (state == IDLE);
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_wdata = mwdata_q;
   assign bus.mem_wmask = wmask_q;
   assign bus.gpr_wen   = wen_q;
   assign bus.gpr_waddr = waddr_q;
   assign bus.gpr_wdata = gdata_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_ysyx_23060201_lsu_wb.sv
// tb_ysyx_23060201_lsu_wb: directed scenarios plus randomized
// instructions checked against a behavioural model of the stage.
module tb_ysyx_23060201_lsu_wb;
   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   ysyx_23060201_lsu_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ysyx_23060201_lsu_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // free-running clock
   always #5 clk = ~clk;

   int          o_req, o_wen, o_done, o_err, o_busy;
   logic        o_tmo, o_unstable, o_we;
   logic [31:0] o_maddr, o_mwdata, o_gdata;
   logic [3:0]  o_mask;
   logic [4:0]  o_gaddr;

   task automatic idle_inputs();
      bus.in_valid    = 1'b0;
      bus.in_is_load  = 1'b0;
      bus.in_is_store = 1'b0;
      bus.in_funct3   = 3'd0;
      bus.in_addr     = '0;
      bus.in_sdata    = '0;
      bus.in_alu_res  = '0;
      bus.in_rd       = '0;
      bus.in_rd_wen   = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = '0;
   endtask

   // issue one instruction, act as memory, record what the stage did
   task automatic run_one(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] alu,
                          input logic [4:0] rd, input logic rdw,
                          input logic [31:0] rdata, input int dly,
                          input logic stray);
      bit seen_end;
      bit fin;
      o_req = 0; o_wen = 0; o_done = 0; o_err = 0; o_busy = 0;
      o_tmo = 0; o_unstable = 0; o_we = 0;
      o_maddr = '0; o_mwdata = '0; o_gdata = '0; o_mask = '0; o_gaddr = '0;
      seen_end = 0;
      fin = 0;
      bus.in_valid    = 1'b1;
      bus.in_is_load  = ld;
      bus.in_is_store = st;
      bus.in_funct3   = f3;
      bus.in_addr     = addr;
      bus.in_sdata    = sd;
      bus.in_alu_res  = alu;
      bus.in_rd       = rd;
      bus.in_rd_wen   = rdw;
      bus.mem_rdata   = rdata;
      bus.mem_ack     = stray;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.mem_ack  = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (bus.mem_req) begin
            if (o_req == 0) begin
               o_maddr = bus.mem_addr; o_mwdata = bus.mem_wdata;
               o_mask = bus.mem_wmask; o_we = bus.mem_we;
            end else if (o_maddr !== bus.mem_addr || o_mwdata !== bus.mem_wdata
                         || o_mask !== bus.mem_wmask || o_we !== bus.mem_we) begin
               o_unstable = 1;
            end
            o_req++;
         end
         if (!bus.in_ready) o_busy++;
         if (bus.gpr_wen) begin
            o_wen++; o_gaddr = bus.gpr_waddr; o_gdata = bus.gpr_wdata;
         end
         if (bus.done) o_done++;
         if (bus.err) o_err++;
         if (bus.done || bus.err) seen_end = 1;
         else if (seen_end && bus.in_ready) begin
            fin = 1;
            break;
         end
         bus.mem_ack = bus.mem_req && (o_req == dly);
         @(posedge clk); #1;
         bus.mem_ack = 1'b0;
      end
      if (!fin) o_tmo = 1;
   endtask

   // what the stage must do for one instruction, from the ISA rules
   task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] alu, input logic [4:0] rd,
                        input logic rdw, input logic [31:0] rdata,
                        output int kind, output logic [31:0] e_maddr,
                        output logic [31:0] e_mwdata, output logic [3:0] e_mask,
                        output logic [31:0] e_gdata, output logic e_wen);
      int sz, o, v;
      logic [31:0] w;
      logic ok;
      sz = 1 << f3[1:0];
      o = int'(addr % 4);
      e_maddr = addr - o;
      e_mwdata = sd << (8 * o);
      e_mask = 4'(((1 << sz) - 1) << o);
      w = rdata >> (8 * o);
      case (f3)
         3'd0: begin v = int'(w % 256); if (v >= 128) v -= 256; e_gdata = 32'(v); end
         3'd1: begin v = int'(w % 65536); if (v >= 32768) v -= 65536; e_gdata = 32'(v); end
         3'd4: e_gdata = w % 256;
         3'd5: e_gdata = w % 65536;
         default: e_gdata = w;
      endcase
      ok = ld ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
      if ((addr % sz) != 0) ok = 0;
      if (ld && st) ok = 0;
      if (!(ld || st)) begin kind = 0; e_gdata = alu; end
      else if (!ok) kind = 3;
      else if (ld) kind = 1;
      else kind = 2;
      e_wen = (kind == 0 || kind == 1) && rdw && (rd != 0);
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got=%b exp=0", bus.in_ready);
      end
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask,
           bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata, bus.done, bus.err} !== '0) begin
         errors++;
         $display("FAIL reset_outs req=%b wen=%b done=%b err=%b addr=%h exp all 0",
                  bus.mem_req, bus.gpr_wen, bus.done, bus.err, bus.mem_addr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_reset got=%b exp=1", bus.in_ready);
      end
   endtask

   task automatic test_alu();
      run_one(0, 0, 3'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1, 32'h0, 1, 0);
      checks++;
      if (o_wen !== 1 || o_gaddr !== 5'd5 || o_gdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL alu_wb wen=%0d waddr=%0d wdata=%h exp 1/5/12345678",
                  o_wen, o_gaddr, o_gdata);
      end
      checks++;
      if (o_done !== 1 || o_busy !== 1 || o_req !== 0 || o_tmo !== 0) begin
         errors++;
         $display("FAIL alu_timing done=%0d busy=%0d req=%0d tmo=%b exp 1/1/0/0",
                  o_done, o_busy, o_req, o_tmo);
      end
   endtask

   task automatic test_load();
      run_one(1, 0, 3'd0, 32'h8000_0003, 32'h0, 32'h0, 5'd7, 1,
              32'h80FF_0000, 3, 0);
      checks++;
      if (o_maddr !== 32'h8000_0000 || o_req !== 3 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL lb_mem addr=%h req=%0d we=%b exp 80000000/3/0",
                  o_maddr, o_req, o_we);
      end
      checks++;
      if (o_wen !== 1 || o_gaddr !== 5'd7 || o_gdata !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL lb_data wen=%0d waddr=%0d wdata=%h exp 1/7/ffffff80",
                  o_wen, o_gaddr, o_gdata);
      end
      run_one(1, 0, 3'd4, 32'h8000_0003, 32'h0, 32'h0, 5'd7, 1,
              32'h80FF_0000, 3, 0);
      checks++;
      if (o_wen !== 1 || o_gdata !== 32'h0000_0080 || o_done !== 1) begin
         errors++;
         $display("FAIL lbu_data wen=%0d wdata=%h done=%0d exp 1/00000080/1",
                  o_wen, o_gdata, o_done);
      end
   endtask

   task automatic test_store();
      run_one(0, 1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 5'd9, 1,
              32'h0, 2, 0);
      checks++;
      if (o_we !== 1'b1 || o_mask !== 4'b1100 || o_mwdata !== 32'hABCD_0000) begin
         errors++;
         $display("FAIL sh_bus we=%b mask=%b wdata=%h exp 1/1100/abcd0000",
                  o_we, o_mask, o_mwdata);
      end
      checks++;
      if (o_done !== 1 || o_wen !== 0 || o_req !== 2 || o_busy !== 2) begin
         errors++;
         $display("FAIL sh_done done=%0d wen=%0d req=%0d busy=%0d exp 1/0/2/2",
                  o_done, o_wen, o_req, o_busy);
      end
   endtask

   task automatic test_err();
      run_one(1, 0, 3'd2, 32'h8000_0002, 32'h0, 32'h0, 5'd3, 1, 32'h0, 1, 0);
      checks++;
      if (o_err !== 1 || o_req !== 0 || o_wen !== 0 || o_done !== 0) begin
         errors++;
         $display("FAIL lw_misalign err=%0d req=%0d wen=%0d done=%0d exp 1/0/0/0",
                  o_err, o_req, o_wen, o_done);
      end
      run_one(1, 0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 5'd3, 1, 32'h0, 1, 0);
      checks++;
      if (o_err !== 1 || o_req !== 0 || o_wen !== 0) begin
         errors++;
         $display("FAIL ld_f3_3 err=%0d req=%0d wen=%0d exp 1/0/0",
                  o_err, o_req, o_wen);
      end
   endtask

   task automatic test_rd0();
      run_one(0, 0, 3'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0, 1, 32'h0, 1, 0);
      checks++;
      if (o_wen !== 0 || o_done !== 1) begin
         errors++;
         $display("FAIL rd0 wen=%0d done=%0d exp 0/1", o_wen, o_done);
      end
   endtask

   task automatic test_reset_mid();
      int wen_c, done_c, req_c, rdy_c;
      wen_c = 0; done_c = 0; req_c = 0; rdy_c = 0;
      bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_is_store = 1'b0;
      bus.in_funct3 = 3'd2; bus.in_addr = 32'h8000_0010;
      bus.in_rd = 5'd4; bus.in_rd_wen = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++; $display("FAIL mid_req_up got=%b exp=1", bus.mem_req);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.mem_req !== 0 || bus.gpr_wen !== 0 || bus.done !== 0 ||
          bus.err !== 0) begin
         errors++;
         $display("FAIL mid_async req=%b wen=%b done=%b err=%b exp 0",
                  bus.mem_req, bus.gpr_wen, bus.done, bus.err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (bus.gpr_wen) wen_c++;
         if (bus.done) done_c++;
         if (bus.mem_req) req_c++;
         if (bus.in_ready) rdy_c++;
         @(posedge clk); #1;
      end
      checks++;
      if (wen_c !== 0 || done_c !== 0 || req_c !== 0 || rdy_c !== 3) begin
         errors++;
         $display("FAIL mid_late_ack wen=%0d done=%0d req=%0d ready=%0d exp 0/0/0/3",
                  wen_c, done_c, req_c, rdy_c);
      end
   endtask

   task automatic test_random();
      logic ld, st, rdw, stray, e_wen;
      logic [2:0] f3;
      logic [31:0] addr, sd, alu, rdata, e_maddr, e_mwdata, e_gdata;
      logic [3:0] e_mask;
      logic [4:0] rd;
      int sel, dly, kind, e_req, e_busy, e_done, e_err, e_w;
      for (int i = 0; i < 120; i++) begin
         sel = $urandom_range(0, 9);
         ld = sel < 4 || sel == 9;
         st = (sel >= 4 && sel < 7) || sel == 9;
         f3 = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 2) != 0) begin
            if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            else if (f3[1:0] == 2'd1) addr[0] = 1'b0;
         end
         sd = $urandom; alu = $urandom; rdata = $urandom;
         rd = 5'($urandom_range(0, 31));
         rdw = $urandom_range(0, 3) != 0;
         dly = $urandom_range(1, 4);
         stray = $urandom_range(0, 3) == 0;
         model(ld, st, f3, addr, sd, alu, rd, rdw, rdata,
               kind, e_maddr, e_mwdata, e_mask, e_gdata, e_wen);
         run_one(ld, st, f3, addr, sd, alu, rd, rdw, rdata, dly, stray);
         e_req  = (kind == 1 || kind == 2) ? dly : 0;
         e_busy = (kind == 1) ? dly + 1 : (kind == 2) ? dly : 1;
         e_done = (kind == 3) ? 0 : 1;
         e_err  = (kind == 3) ? 1 : 0;
         e_w    = e_wen ? 1 : 0;
         checks++;
         if (o_req !== e_req || o_busy !== e_busy || o_tmo !== 0) begin
            errors++;
            $display("FAIL rnd%0d timing req=%0d/%0d busy=%0d/%0d tmo=%b",
                     i, o_req, e_req, o_busy, e_busy, o_tmo);
         end
         checks++;
         if (o_done !== e_done || o_err !== e_err || o_wen !== e_w) begin
            errors++;
            $display("FAIL rnd%0d pulses done=%0d/%0d err=%0d/%0d wen=%0d/%0d",
                     i, o_done, e_done, o_err, e_err, o_wen, e_w);
         end
         if (e_wen) begin
            checks++;
            if (o_gaddr !== rd || o_gdata !== e_gdata) begin
               errors++;
               $display("FAIL rnd%0d gpr waddr=%0d/%0d wdata=%h/%h",
                        i, o_gaddr, rd, o_gdata, e_gdata);
            end
         end
         if (kind == 1 || kind == 2) begin
            checks++;
            if (o_maddr !== e_maddr || o_we !== (kind == 2) || o_unstable !== 0) begin
               errors++;
               $display("FAIL rnd%0d mem addr=%h/%h we=%b unstable=%b",
                        i, o_maddr, e_maddr, o_we, o_unstable);
            end
         end
         if (kind == 2) begin
            checks++;
            if (o_mask !== e_mask || o_mwdata !== e_mwdata) begin
               errors++;
               $display("FAIL rnd%0d store mask=%b/%b wdata=%h/%h",
                        i, o_mask, e_mask, o_mwdata, e_mwdata);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_err();
      test_rd0();
      test_reset_mid();
      idle_inputs();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
